regfile_wb_arbiter: RTL and testbench
=====================================

# regfile_wb_arbiter

Shares the register file's single write port among several writeback requesters (load unit, ALU, CSR path, ...) with round-robin arbitration and a registered write stage. It also sequences environment calls: it drains the write stage, holds the register file's `ecall` until `ecall_done`, then acknowledges the pipeline. It sits between the pipeline writeback sources and the register file's `write_enable`/`write_register`/`write_value` and `ecall`/`ecall_done` pins.

## Interface
- `NUM_REQ`, default 3: number of writeback requesters; legal range 2..8; index 0 is the lowest index.
- `XLEN`, default 64: data width.
- `REG_W`, default 5: register index width.

Ports:
- `clk`  in  1  the single clock; all state is on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NUM_REQ  per-requester write request.
- `req_reg`  in  NUM_REQ*REG_W  destination index; requester i uses slice [i*REG_W +: REG_W].
- `req_data`  in  NUM_REQ*XLEN  write data; requester i uses slice [i*XLEN +: XLEN].
- `req_ready`  out  NUM_REQ  one-hot-or-zero grant; combinational.
- `write_enable`  out  1  registered write strobe to the register file.
- `write_register`  out  REG_W  registered destination index.
- `write_value`  out  XLEN  registered write data.
- `ecall_req`  in  1  level request from the pipeline; held until `ecall_ack`.
- `ecall_ack`  out  1  one-cycle pulse when the ecall is complete.
- `ecall`  out  1  registered level to the register file.
- `ecall_done`  in  1  completion level from the register file.
- `busy`  out  1  high when the FSM state is not IDLE.

## Operation
- FSM states: IDLE, DRAIN, CALL, ACK. Reset state is IDLE.
- IDLE:
  - If `ecall_req` is high, go to DRAIN. No grant is issued in that cycle.
  - Otherwise grant one valid requester. The search starts at `rr_ptr` and wraps modulo NUM_REQ. `req_ready[i]` is 1 only for the granted index.
- A transfer occurs when `req_valid[i]` and `req_ready[i]` are both high.
- On a transfer: set `rr_ptr` to (i+1) mod NUM_REQ. Register `write_register` from `req_reg[i]` and `write_value` from `req_data[i]`.
  - `write_enable` is set to 1 only if `req_reg[i]` is not 0.
  - A write to x0 is accepted and dropped.
- No transfer: `write_enable` is 0 next cycle. `write_register` and `write_value` hold their previous values.
- DRAIN: lasts one cycle; no grants. Sets `ecall` to 1 at the exit edge. Next state is CALL.
- CALL:
  - `ecall` is held at 1; no grants.
  - When `ecall_done` is sampled high, clear `ecall`, pulse `ecall_ack`, and go to ACK.
- ACK: lasts one cycle; no grants. `ecall_ack` is 1. Next state is IDLE.
- `ecall_req` falling during DRAIN or CALL is ignored. The sequence always completes.
- `rr_ptr` is unchanged by ecalls.

## Timing
- Reset values:
  - `write_enable`, `write_register`, `write_value`, `ecall`, `ecall_ack` are 0.
  - `busy` is 0 and `rr_ptr` is 0.
  - `req_ready` is forced to 0 while `reset` is low.
- Write latency: a transfer in cycle t drives `write_enable` high in cycle t+1. The register file commits it at the edge ending t+1. Throughput is one write per cycle.
- `req_ready` depends combinationally on `req_valid`, `rr_ptr`, state and `ecall_req`. It must not depend on `req_reg` or `req_data`.
- Ecall sequence, with `ecall_req` first sampled in IDLE at cycle t:
  - DRAIN is cycle t+1; `ecall` rises in t+2.
  - If `ecall_done` is seen in cycle d, `ecall` falls in d+1 and `ecall_ack` is high in d+1.
  - IDLE resumes, and grants are possible, in d+2.
- Simultaneous ecall and write requests: `ecall_req` wins in IDLE. The write waits until after ACK.
- Asynchronous reset mid-CALL: `ecall` drops immediately and the FSM returns to IDLE. No `ecall_ack` is issued.
- All requesters valid: grants rotate 0,1,2,0,... No requester waits more than NUM_REQ-1 grants.

## Test plan
- Reset, then `req_valid`=3'b001, reg=5, data=0xAA: `req_ready`=001 the same cycle; next cycle `write_enable`=1, `write_register`=5, `write_value`=0xAA.
- `req_valid`=3'b111 held for 6 cycles with distinct regs: grant order 0,1,2,0,1,2; each write appears one cycle after its grant.
- Requester 1 writes reg 0 with data 0xFF: `req_ready[1]`=1, but `write_enable` stays 0 next cycle.
- Write in cycle t, `ecall_req` in t+1: `write_enable` high in t+1; DRAIN in t+2; `ecall`=1 from t+3; model `ecall_done` 2 cycles later; `ecall_ack` is one pulse; `req_ready`=0 throughout; grants resume 2 cycles after `ecall_done`.
- Drop `reset` low during CALL: `ecall`, `busy` and `write_enable` are 0 immediately, with no clock edge; after release, the FSM is in IDLE and the first grant goes to the lowest valid index.
- `ecall_req` and `req_valid`=3'b010 asserted together: no grant until ACK completes, then requester 1 is granted.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter for the register file's single write port, with a registered
// write stage and an ecall sequencer (drain, hold ecall until done, acknowledge).
module regfile_wb_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int XLEN    = 64,
    parameter int REG_W   = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*REG_W-1:0] req_reg,
    input  logic [NUM_REQ*XLEN-1:0]  req_data,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     write_enable,
    output logic [REG_W-1:0]         write_register,
    output logic [XLEN-1:0]          write_value,
    input  logic                     ecall_req,
    output logic                     ecall_ack,
    output logic                     ecall,
    input  logic                     ecall_done,
    output logic                     busy
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_CALL  = 2'd2,
        ST_ACK   = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [PTR_W-1:0]   r_rr_ptr;
    logic [PTR_W-1:0]   w_sel;
    logic [PTR_W-1:0]   w_next_ptr;
    logic               w_found;
    logic               w_grant_en;
    logic [NUM_REQ-1:0] w_grant;
    logic [REG_W-1:0]   w_sel_reg;
    logic [XLEN-1:0]    w_sel_data;
    logic               r_write_enable;
    logic [REG_W-1:0]   r_write_register;
    logic [XLEN-1:0]    r_write_value;
    logic               r_ecall;
    logic               r_ecall_ack;

    // Round-robin search: first pass from rr_ptr upward, second pass wraps from index 0.
    always_comb begin
        w_sel   = r_rr_ptr;
        w_found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_found && req_valid[i] && (PTR_W'(i) >= r_rr_ptr)) begin
                w_found = 1'b1;
                w_sel   = PTR_W'(i);
            end else begin
                w_found = w_found;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_found && req_valid[i]) begin
                w_found = 1'b1;
                w_sel   = PTR_W'(i);
            end else begin
                w_found = w_found;
            end
        end
    end

    // Grant only in IDLE with no pending ecall; reset masks the grant asynchronously.
    always_comb begin
        w_grant_en = reset && (r_state == ST_IDLE) && !ecall_req && w_found;
        if (w_grant_en) begin
            w_grant = NUM_REQ'(1) << w_sel;
        end else begin
            w_grant = '0;
        end
        if (w_sel == PTR_W'(NUM_REQ - 1)) begin
            w_next_ptr = '0;
        end else begin
            w_next_ptr = w_sel + PTR_W'(1);
        end
    end

    // Select the granted requester's destination and data.
    always_comb begin
        w_sel_reg  = '0;
        w_sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (PTR_W'(i) == w_sel) begin
                w_sel_reg  = req_reg[i*REG_W +: REG_W];
                w_sel_data = req_data[i*XLEN +: XLEN];
            end else begin
                w_sel_reg  = w_sel_reg;
                w_sel_data = w_sel_data;
            end
        end
    end

    // Next-state logic; DRAIN and ACK are single-cycle, ecall_req drop is ignored once started.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (ecall_req) begin
                    w_next_state = ST_DRAIN;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_DRAIN: w_next_state = ST_CALL;
            ST_CALL: begin
                if (ecall_done) begin
                    w_next_state = ST_ACK;
                end else begin
                    w_next_state = ST_CALL;
                end
            end
            ST_ACK:  w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Write stage; x0 writes are accepted but never strobed to the register file.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rr_ptr         <= '0;
            r_write_enable   <= 1'b0;
            r_write_register <= '0;
            r_write_value    <= '0;
        end else if (w_grant_en) begin
            r_rr_ptr         <= w_next_ptr;
            r_write_enable   <= (w_sel_reg != '0);
            r_write_register <= w_sel_reg;
            r_write_value    <= w_sel_data;
        end else begin
            r_write_enable   <= 1'b0;
        end
    end

    // Ecall handshake outputs: ecall rises leaving DRAIN, falls with the ack pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ecall     <= 1'b0;
            r_ecall_ack <= 1'b0;
        end else begin
            r_ecall_ack <= (r_state == ST_CALL) && ecall_done;
            if (r_state == ST_DRAIN) begin
                r_ecall <= 1'b1;
            end else if ((r_state == ST_CALL) && ecall_done) begin
                r_ecall <= 1'b0;
            end else begin
                r_ecall <= r_ecall;
            end
        end
    end

    assign req_ready      = w_grant;
    assign write_enable   = r_write_enable;
    assign write_register = r_write_register;
    assign write_value    = r_write_value;
    assign ecall          = r_ecall;
    assign ecall_ack      = r_ecall_ack;
    assign busy           = (r_state != ST_IDLE);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: a vector table for arbitration and the write
// stage, then hand-written ecall and reset sequences.
module tb_regfile_wb_arbiter;

    logic          clk = 1'b0;
    logic          reset;
    logic [2:0]    req_valid;
    logic [14:0]   req_reg;
    logic [191:0]  req_data;
    logic [2:0]    req_ready;
    logic          write_enable;
    logic [4:0]    write_register;
    logic [63:0]   write_value;
    logic          ecall_req;
    logic          ecall_ack;
    logic          ecall;
    logic          ecall_done;
    logic          busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0]        valid;
        logic [2:0][4:0]   rg;
        logic [2:0][63:0]  dt;
        logic [2:0]        ready;
        logic              we;
        logic [4:0]        wreg;
        logic [63:0]       wval;
    } vec_t;

    vec_t vecs [12];

    regfile_wb_arbiter #(.NUM_REQ(3), .XLEN(64), .REG_W(5)) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_reg        (req_reg),
        .req_data       (req_data),
        .req_ready      (req_ready),
        .write_enable   (write_enable),
        .write_register (write_register),
        .write_value    (write_value),
        .ecall_req      (ecall_req),
        .ecall_ack      (ecall_ack),
        .ecall          (ecall),
        .ecall_done     (ecall_done),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_vec(input int idx, input logic [2:0] valid,
                           input logic [4:0] r2, input logic [4:0] r1, input logic [4:0] r0,
                           input logic [63:0] d2, input logic [63:0] d1, input logic [63:0] d0,
                           input logic [2:0] ready, input logic we,
                           input logic [4:0] wreg, input logic [63:0] wval);
        vecs[idx].valid = valid;
        vecs[idx].rg    = {r2, r1, r0};
        vecs[idx].dt    = {d2, d1, d0};
        vecs[idx].ready = ready;
        vecs[idx].we    = we;
        vecs[idx].wreg  = wreg;
        vecs[idx].wval  = wval;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // rr_ptr evolves across rows: 0 -> 1 after row 0, rotation from 1 for rows 1-6.
        set_vec(0,  3'b001, 5'd0,  5'd0, 5'd5, 64'h0,   64'h0,  64'hAA,  3'b001, 1'b1, 5'd5,  64'hAA);
        set_vec(1,  3'b111, 5'd3,  5'd2, 5'd1, 64'h30,  64'h20, 64'h10,  3'b010, 1'b1, 5'd2,  64'h20);
        set_vec(2,  3'b111, 5'd3,  5'd2, 5'd1, 64'h30,  64'h20, 64'h10,  3'b100, 1'b1, 5'd3,  64'h30);
        set_vec(3,  3'b111, 5'd3,  5'd2, 5'd1, 64'h30,  64'h20, 64'h10,  3'b001, 1'b1, 5'd1,  64'h10);
        set_vec(4,  3'b111, 5'd3,  5'd2, 5'd1, 64'h30,  64'h20, 64'h10,  3'b010, 1'b1, 5'd2,  64'h20);
        set_vec(5,  3'b111, 5'd3,  5'd2, 5'd1, 64'h30,  64'h20, 64'h10,  3'b100, 1'b1, 5'd3,  64'h30);
        set_vec(6,  3'b111, 5'd3,  5'd2, 5'd1, 64'h30,  64'h20, 64'h10,  3'b001, 1'b1, 5'd1,  64'h10);
        set_vec(7,  3'b000, 5'd9,  5'd9, 5'd9, 64'h5,   64'h5,  64'h5,   3'b000, 1'b0, 5'd1,  64'h10);
        set_vec(8,  3'b010, 5'd0,  5'd0, 5'd0, 64'h0,   64'hFF, 64'h0,   3'b010, 1'b0, 5'd0,  64'hFF);
        set_vec(9,  3'b011, 5'd0,  5'd9, 5'd7, 64'h0,   64'h99, 64'h77,  3'b001, 1'b1, 5'd7,  64'h77);
        set_vec(10, 3'b101, 5'd6,  5'd0, 5'd4, 64'h66,  64'h0,  64'h44,  3'b100, 1'b1, 5'd6,  64'h66);
        set_vec(11, 3'b110, 5'd10, 5'd8, 5'd0, 64'hAA0, 64'h88, 64'h0,   3'b010, 1'b1, 5'd8,  64'h88);

        reset      = 1'b0;
        req_valid  = 3'b111;
        req_reg    = '0;
        req_data   = '0;
        ecall_req  = 1'b0;
        ecall_done = 1'b0;
        #1;
        chk("reset_ready", 64'(req_ready), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_we",    64'(write_enable), 64'd0);
        chk("reset_wreg",  64'(write_register), 64'd0);
        chk("reset_wval",  write_value, 64'd0);
        chk("reset_ecall", 64'(ecall), 64'd0);
        chk("reset_ack",   64'(ecall_ack), 64'd0);
        chk("reset_busy",  64'(busy), 64'd0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 12; i++) begin
            req_valid = vecs[i].valid;
            req_reg   = vecs[i].rg;
            req_data  = vecs[i].dt;
            #1;
            chk($sformatf("vec%0d_ready", i), 64'(req_ready), 64'(vecs[i].ready));
            tick();
            chk($sformatf("vec%0d_we", i),   64'(write_enable), 64'(vecs[i].we));
            chk($sformatf("vec%0d_wreg", i), 64'(write_register), 64'(vecs[i].wreg));
            chk($sformatf("vec%0d_wval", i), write_value, vecs[i].wval);
        end

        // Write then ecall; rr_ptr is 2 here.
        req_valid = 3'b100;
        req_reg   = {5'd12, 5'd0, 5'd0};
        req_data  = {64'hC0, 64'h0, 64'h0};
        #1;
        chk("ecA_t_ready", 64'(req_ready), 64'b100);
        tick();
        chk("ecA_t1_we",   64'(write_enable), 64'd1);
        chk("ecA_t1_wreg", 64'(write_register), 64'd12);
        ecall_req = 1'b1;
        req_valid = 3'b111;
        req_reg   = {5'd23, 5'd22, 5'd21};
        req_data  = {64'h300, 64'h200, 64'h100};
        #1;
        chk("ecA_t1_ready", 64'(req_ready), 64'd0);
        chk("ecA_t1_busy",  64'(busy), 64'd0);
        tick();
        chk("ecA_drain_busy",  64'(busy), 64'd1);
        chk("ecA_drain_ecall", 64'(ecall), 64'd0);
        chk("ecA_drain_ready", 64'(req_ready), 64'd0);
        chk("ecA_drain_we",    64'(write_enable), 64'd0);
        tick();
        chk("ecA_call_ecall", 64'(ecall), 64'd1);
        chk("ecA_call_ready", 64'(req_ready), 64'd0);
        tick();
        chk("ecA_t4_ecall", 64'(ecall), 64'd1);
        chk("ecA_t4_ack",   64'(ecall_ack), 64'd0);
        tick();
        chk("ecA_d_ecall", 64'(ecall), 64'd1);
        ecall_done = 1'b1;
        #1;
        chk("ecA_d_ready", 64'(req_ready), 64'd0);
        tick();
        chk("ecA_ack_ecall", 64'(ecall), 64'd0);
        chk("ecA_ack_pulse", 64'(ecall_ack), 64'd1);
        chk("ecA_ack_busy",  64'(busy), 64'd1);
        chk("ecA_ack_ready", 64'(req_ready), 64'd0);
        ecall_done = 1'b0;
        ecall_req  = 1'b0;
        tick();
        chk("ecA_idle_ack",   64'(ecall_ack), 64'd0);
        chk("ecA_idle_busy",  64'(busy), 64'd0);
        chk("ecA_idle_ready", 64'(req_ready), 64'b001);
        tick();
        chk("ecA_resume_we",   64'(write_enable), 64'd1);
        chk("ecA_resume_wreg", 64'(write_register), 64'd21);
        chk("ecA_resume_wval", write_value, 64'h100);
        req_valid = 3'b000;

        // Ecall and write together; ecall wins.
        ecall_req = 1'b1;
        req_valid = 3'b010;
        req_reg   = {5'd0, 5'd17, 5'd0};
        req_data  = {64'h0, 64'h1717, 64'h0};
        #1;
        chk("ecB_idle_ready", 64'(req_ready), 64'd0);
        tick();
        chk("ecB_drain_ready", 64'(req_ready), 64'd0);
        tick();
        chk("ecB_call_ecall", 64'(ecall), 64'd1);
        ecall_done = 1'b1;
        #1;
        chk("ecB_call_ready", 64'(req_ready), 64'd0);
        tick();
        chk("ecB_ack_pulse", 64'(ecall_ack), 64'd1);
        ecall_done = 1'b0;
        ecall_req  = 1'b0;
        #1;
        chk("ecB_ack_ready", 64'(req_ready), 64'd0);
        tick();
        chk("ecB_idle_ready", 64'(req_ready), 64'b010);
        chk("ecB_idle_ack",   64'(ecall_ack), 64'd0);
        tick();
        chk("ecB_we",   64'(write_enable), 64'd1);
        chk("ecB_wreg", 64'(write_register), 64'd17);
        chk("ecB_wval", write_value, 64'h1717);
        req_valid = 3'b000;

        // Asynchronous reset during CALL; rr_ptr is 2 before reset.
        ecall_req = 1'b1;
        tick();
        tick();
        chk("ecC_call_ecall", 64'(ecall), 64'd1);
        chk("ecC_call_busy",  64'(busy), 64'd1);
        req_valid = 3'b110;
        req_reg   = {5'd26, 5'd25, 5'd0};
        req_data  = {64'h2626, 64'h2525, 64'h0};
        #2;
        reset = 1'b0;
        #1;
        chk("ecC_rst_ecall", 64'(ecall), 64'd0);
        chk("ecC_rst_busy",  64'(busy), 64'd0);
        chk("ecC_rst_we",    64'(write_enable), 64'd0);
        chk("ecC_rst_ack",   64'(ecall_ack), 64'd0);
        chk("ecC_rst_ready", 64'(req_ready), 64'd0);
        ecall_req = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("ecC_rel_ready", 64'(req_ready), 64'b010);
        chk("ecC_rel_busy",  64'(busy), 64'd0);
        tick();
        chk("ecC_rel_ack",  64'(ecall_ack), 64'd0);
        chk("ecC_rel_we",   64'(write_enable), 64'd1);
        chk("ecC_rel_wreg", 64'(write_register), 64'd25);
        req_valid = 3'b000;

        // Reset while a write strobe is high.
        req_valid = 3'b001;
        req_reg   = {5'd0, 5'd0, 5'd31};
        req_data  = {64'h0, 64'h0, 64'h31};
        #1;
        chk("rstW_ready", 64'(req_ready), 64'b001);
        tick();
        chk("rstW_we", 64'(write_enable), 64'd1);
        req_valid = 3'b000;
        #2;
        reset = 1'b0;
        #1;
        chk("rstW_rst_we",   64'(write_enable), 64'd0);
        chk("rstW_rst_wreg", 64'(write_register), 64'd0);
        chk("rstW_rst_wval", write_value, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
